// File: rtl/int_ctrl.sv
// int_ctrl: multi-source interrupt controller.
// Per-source synchronizer, glitch filter and rising-edge pending latch,
// a software enable mask, a fixed-priority arbiter (lowest index wins) and a
// single-level request/acknowledge/return handshake with the CPU.
// All outputs come straight from flops.
module int_ctrl #(
  parameter int N     = 4,
  parameter int VEC_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     IRQ,
  input  logic [N-1:0]     MASK,
  input  logic             WMASK,
  input  logic             INTA,
  input  logic             RTI,
  output logic             REQI,
  output logic [VEC_W-1:0] VECTOR,
  output logic [N-1:0]     PEND,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_n;

  // Front end: three sync/filter stages plus the delayed qualified level.
  logic [N-1:0] s1, s2, s3;
  logic [N-1:0] qual, qual_d, rise;

  // Pending latch, enable mask and the eligible set seen by the arbiter.
  logic [N-1:0] pend, pend_n, clr;
  logic [N-1:0] mask;
  logic [N-1:0] elig;

  logic [VEC_W-1:0] sel;
  logic [VEC_W-1:0] vector_n;
  logic             accept;

  // A level is qualified only once it has been seen in two consecutive
  // synchronized samples, so a single-sample high at s2 never qualifies.
  assign qual = s2 & s3;
  assign rise = qual & ~qual_d;
  assign elig = pend & mask;
  assign PEND = pend;

  // Synchronizer chain and filter history for every source.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      qual_d <= '0;
    end else begin
      s1     <= IRQ;
      s2     <= s1;
      s3     <= s2;
      qual_d <= qual;
    end
  end

  // Software-writable enable mask.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask <= '0;
    end else if (WMASK) begin
      mask <= MASK;
    end
  end

  // Pending update: a new edge on the same cycle as its acknowledge wins,
  // so the fresh event is not lost.
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[VECTOR] = 1'b1;
    end
    pend_n = (pend & ~clr) | rise;
  end

  // Pending flags register, independent of the mask.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= '0;
    end else begin
      pend <= pend_n;
    end
  end

  // Fixed-priority arbiter: scan downwards so the lowest set index is left.
  always_comb begin
    sel = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (elig[i-1]) begin
        sel = VEC_W'(i - 1);
      end
    end
  end

  // Handshake next-state and next-output logic.
  // INTA in REQ is evaluated before the empty-E check so an acknowledge that
  // coincides with a mask write emptying E is still accepted.
  always_comb begin
    state_n  = state;
    vector_n = VECTOR;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          vector_n = sel;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (INTA) begin
          accept  = 1'b1;
          state_n = SERVICE;
        end else if (~|elig) begin
          state_n = IDLE;
        end else begin
          vector_n = sel;
        end
      end
      SERVICE: begin
        if (RTI) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and registered CPU-facing outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      REQI   <= 1'b0;
      BUSY   <= 1'b0;
      VECTOR <= '0;
    end else begin
      state  <= state_n;
      REQI   <= (state_n == REQ);
      BUSY   <= (state_n == SERVICE);
      VECTOR <= vector_n;
    end
  end

endmodule
